// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word requests into word accesses on a data memory,
// with read-modify-write for SB/SH. Define LSU_PERF_CNT_EN to add ld/st/err counters.

module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
  output logic [15:0]       err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Misalignment, reserved funct3 and unsigned-store encodings are all rejected.
  function automatic logic is_illegal(input logic [2:0] f3, input logic we, input logic [1:0] lane);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    half    = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    res = {{16{half[15]}}, half};
      F3_W:    res = word;
      F3_BU:   res = {24'h00_0000, shifted[7:0]};
      F3_HU:   res = {16'h0000, half};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wdata);
    logic [31:0] res;
    res = old;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          res[31:16] = wdata[15:0];
        end else begin
          res[15:0] = wdata[15:0];
        end
      end
      F3_W:    res = wdata;
      default: res = old;
    endcase
    return res;
  endfunction

  state_t              state_r, state_n_s;
  logic                we_r;
  logic [2:0]          funct3_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                accept_s;

  logic                req_ready_r, req_ready_n_s;
  logic                resp_valid_r, resp_valid_n_s;
  logic [DATA_W-1:0]   resp_rdata_r, resp_rdata_n_s;
  logic                resp_err_r, resp_err_n_s;
  logic                mem_read_r, mem_read_n_s;
  logic                mem_write_r, mem_write_n_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_n_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_n_s;

  // Next state plus next value of every registered output; memory-side signals default to 0.
  always_comb begin
    state_n_s      = state_r;
    accept_s       = 1'b0;
    resp_valid_n_s = 1'b0;
    resp_rdata_n_s = resp_rdata_r;
    resp_err_n_s   = resp_err_r;
    mem_read_n_s   = 1'b0;
    mem_write_n_s  = 1'b0;
    mem_addr_n_s   = '0;
    mem_wdata_n_s  = '0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s = 1'b1;
          if (is_illegal(req_funct3, req_we, req_addr[1:0])) begin
            state_n_s      = RESP;
            resp_valid_n_s = 1'b1;
            resp_rdata_n_s = '0;
            resp_err_n_s   = 1'b1;
          end else if (!req_we || (req_funct3 != F3_W)) begin
            state_n_s    = RD;
            mem_read_n_s = 1'b1;
            mem_addr_n_s = {req_addr[ADDR_W-1:2], 2'b00};
          end else begin
            state_n_s     = WR;
            mem_write_n_s = 1'b1;
            mem_addr_n_s  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_n_s = req_wdata;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      // mem_read_data is sampled at the edge closing the RD cycle.
      RD: begin
        if (!we_r) begin
          state_n_s      = RESP;
          resp_valid_n_s = 1'b1;
          resp_rdata_n_s = load_extract(funct3_r, addr_r[1:0], mem_read_data);
          resp_err_n_s   = 1'b0;
        end else begin
          state_n_s     = WR;
          mem_write_n_s = 1'b1;
          mem_addr_n_s  = {addr_r[ADDR_W-1:2], 2'b00};
          mem_wdata_n_s = store_merge(funct3_r, addr_r[1:0], mem_read_data, wdata_r);
        end
      end
      WR: begin
        state_n_s      = RESP;
        resp_valid_n_s = 1'b1;
        resp_rdata_n_s = '0;
        resp_err_n_s   = 1'b0;
      end
      RESP:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
    req_ready_n_s = (state_n_s == IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= '0;
      wdata_r      <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
    end else begin
      state_r      <= state_n_s;
      if (accept_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
      end
      req_ready_r  <= req_ready_n_s;
      resp_valid_r <= resp_valid_n_s;
      resp_rdata_r <= resp_rdata_n_s;
      resp_err_r   <= resp_err_n_s;
      mem_read_r   <= mem_read_n_s;
      mem_write_r  <= mem_write_n_s;
      mem_addr_r   <= mem_addr_n_s;
      mem_wdata_r  <= mem_wdata_n_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = resp_rdata_r;
  assign resp_err       = resp_err_r;
  assign MemRead        = mem_read_r;
  assign MemWrite       = mem_write_r;
  assign mem_address    = mem_addr_r;
  assign mem_write_data = mem_wdata_r;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_count_r;
  logic [31:0] st_count_r;
  logic [15:0] err_count_r;

  // Each completed transaction is classified during its RESP cycle; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_count_r  <= 32'd0;
      st_count_r  <= 32'd0;
      err_count_r <= 16'd0;
    end else if (state_r == RESP) begin
      if (resp_err_r) begin
        err_count_r <= err_count_r + 16'd1;
      end else if (we_r) begin
        st_count_r <= st_count_r + 32'd1;
      end else begin
        ld_count_r <= ld_count_r + 32'd1;
      end
    end
  end

  assign ld_count  = ld_count_r;
  assign st_count  = st_count_r;
  assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word-addressed memory model
// and a queue of expected responses.

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_count;
  logic [31:0] st_count;
  logic [15:0] err_count;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef LSU_PERF_CNT_EN
    ,
    .ld_count       (ld_count),
    .st_count       (st_count),
    .err_count      (err_count)
`endif
  );

  assign mem_read_data = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (MemWrite) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive one request, follow it to its response and compare against the queued expectation.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_wdata);
    exp_t        e;
    int          cyc;
    int          rd;
    int          wr;
    logic [31:0] waddr;
    waddr   = {addr[31:2], 2'b00};
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; rd = 0; wr = 0;
    while (resp_valid !== 1'b1 && cyc < 8) begin
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      check("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
      if (MemRead === 1'b1) begin
        rd++;
        check("rd_addr", mem_address, waddr);
      end
      if (MemWrite === 1'b1) begin
        wr++;
        check("wr_addr", mem_address, waddr);
        check("wr_data", mem_write_data, exp_wdata);
      end
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_lat", cyc, e.lat);
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
    check("resp_mem_idle", {30'd0, MemRead, MemWrite}, 32'd0);
    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
    check("rd_cycles", rd, exp_rd);
    check("wr_cycles", wr, exp_wr);
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
    check("rdata_hold", resp_rdata, e.rdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rvalid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_rerr"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_memrw"}, {30'd0, MemRead, MemWrite}, 32'd0);
    check({tag, "_maddr"}, mem_address, 32'd0);
    check({tag, "_mwdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    pl_en = 1'b0; pl_idx = 10'd0; pl_data = 32'd0;
    preload(10'd0, 32'h8070_F0A5);
    preload(10'd1, 32'h1122_3344);
    preload(10'd2, 32'h0000_0000);
    preload(10'd3, 32'hCAFE_F00D);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Loads with lane extract and sign/zero extension
    do_req(1'b0, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFA5, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b100, 32'd3, 32'd0, 32'h0000_0080, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b101, 32'd0, 32'd0, 32'h0000_F0A5, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b001, 32'd2, 32'd0, 32'hFFFF_8070, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b010, 32'd0, 32'd0, 32'h8070_F0A5, 1'b0, 2, 1, 0, 32'd0);

    // Sub-word stores: read-modify-write
    do_req(1'b1, 3'b000, 32'd6, 32'h1234_56AB, 32'd0, 1'b0, 3, 1, 1, 32'h11AB_3344);
    do_req(1'b0, 3'b010, 32'd4, 32'd0, 32'h11AB_3344, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b1, 3'b001, 32'd4, 32'h9999_5566, 32'd0, 1'b0, 3, 1, 1, 32'h11AB_5566);
    do_req(1'b0, 3'b101, 32'd4, 32'd0, 32'h0000_5566, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b000, 32'd7, 32'd0, 32'h0000_0011, 1'b0, 2, 1, 0, 32'd0);

    // Errors: no memory access, rdata forced to zero
    do_req(1'b1, 3'b001, 32'd1, 32'h0000_7777, 32'd0, 1'b1, 1, 0, 0, 32'd0);
    do_req(1'b0, 3'b010, 32'd2, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0);
    do_req(1'b0, 3'b011, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0);
    do_req(1'b1, 3'b100, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0);
    do_req(1'b0, 3'b101, 32'd3, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0);

    // Full-word store then loads from it
    do_req(1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0, 1, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b001, 32'd10, 32'd0, 32'hFFFF_DEAD, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b100, 32'd9, 32'd0, 32'h0000_00BE, 1'b0, 2, 1, 0, 32'd0);

    // Reset during the RD cycle of an SB aborts it
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'd12;
    req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_rd", {31'd0, MemRead}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      check("abort_no_write", {31'd0, MemWrite}, 32'd0);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
    end
    check("abort_mem", mem[3], 32'hCAFE_F00D);

    // Mixed traffic after reset: three loads, two stores, one misaligned
    do_req(1'b0, 3'b010, 32'd0, 32'd0, 32'h8070_F0A5, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b000, 32'd4, 32'd0, 32'h0000_0066, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b0, 3'b100, 32'd1, 32'd0, 32'h0000_00F0, 1'b0, 2, 1, 0, 32'd0);
    do_req(1'b1, 3'b010, 32'd12, 32'h1234_5678, 32'd0, 1'b0, 2, 0, 1, 32'h1234_5678);
    do_req(1'b1, 3'b000, 32'd13, 32'h0000_00EE, 32'd0, 1'b0, 3, 1, 1, 32'h1234_EE78);
    do_req(1'b0, 3'b001, 32'd3, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0);
`ifdef LSU_PERF_CNT_EN
    check("ld_count", ld_count, 32'd3);
    check("st_count", st_count, 32'd2);
    check("err_count", {16'd0, err_count}, 32'd1);
`endif
    do_req(1'b0, 3'b010, 32'd12, 32'd0, 32'h1234_EE78, 1'b0, 2, 1, 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
